prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 31 +++
 rtl/prog_loader.sv | 155 +++++++++++++++
 tb/tb_prog_loader.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Program-loader bus bundle: upstream word stream, RAM write port and
// processor control. The host/bench side uses the master modport; the loader
// itself uses the slave modport.
interface prog_loader_if #(
    parameter int WIDTH  = 6,
    parameter int AWIDTH = 4
);
    logic              start;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              in_ready;
    logic [AWIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_data;
    logic              mem_drive;
    logic              mem_wr_n;
    logic              cpu_reset;
    logic              done;
    logic              error;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_addr, mem_data, mem_drive, mem_wr_n,
        input  cpu_reset, done, error
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_addr, mem_data, mem_drive, mem_wr_n,
        output cpu_reset, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: receives 2**AWIDTH words over a valid/ready stream and
// writes each into an external RAM with a two-cycle write (strobe low, then
// strobe high with address/data held). The processor is held in reset until
// the load completes.
// Optional build macro PROG_LOADER_CHECKSUM_EN: after the last word, one extra
// word is received and compared with the running sum of all loaded words.
module prog_loader #(
    parameter int WIDTH  = 6,
    parameter int AWIDTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    prog_loader_if.slave bus
);

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_WRITE, S_STROBE, S_CHECK, S_DONE, S_ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_WRITE, S_STROBE, S_DONE
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  word_q, word_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0]  acc_q, acc_d;
`endif

    // State, word counter, latched word and checksum registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    // Next-state logic: accept a word, write it, strobe it, advance
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RECV;
                    cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            S_RECV: begin
                if (bus.in_valid) begin
                    word_d  = bus.in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                    acc_d   = acc_q + bus.in_data;
`endif
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = S_STROBE;
            end
            S_STROBE: begin
                // The counter saturates at the last address; only a restart
                // brings it back to zero.
                if (cnt_q == '1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    cnt_d   = cnt_q + AWIDTH'(1);
                    state_d = S_RECV;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHECK: begin
                // The checksum word is compared only, never written to RAM.
                if (bus.in_valid) begin
                    state_d = (bus.in_data == acc_q) ? S_DONE : S_ERROR;
                end
            end
            S_ERROR: begin
                if (bus.start) begin
                    state_d = S_RECV;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
`endif
            S_DONE: begin
                if (bus.start) begin
                    state_d = S_RECV;
                    cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: strobe low only in WRITE, bus driven in WRITE and STROBE
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.mem_addr  = cnt_q;
        bus.mem_data  = word_q;
        bus.mem_drive = 1'b0;
        bus.mem_wr_n  = 1'b1;
        bus.cpu_reset = 1'b1;
        bus.done      = 1'b0;
        bus.error     = 1'b0;
        case (state_q)
            S_RECV:   bus.in_ready = 1'b1;
            S_WRITE: begin
                bus.mem_drive = 1'b1;
                bus.mem_wr_n  = 1'b0;
            end
            S_STROBE: bus.mem_drive = 1'b1;
            S_DONE: begin
                bus.done      = 1'b1;
                bus.cpu_reset = 1'b0;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHECK:  bus.in_ready = 1'b1;
            S_ERROR:  bus.error    = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader with a behavioural RAM that captures on
// the rising edge of mem_wr_n.
module tb_prog_loader;
    localparam int WIDTH  = 6;
    localparam int AWIDTH = 4;

    logic clock = 1'b0;
    logic reset;
    int vectors = 0;
    int miscompares = 0;
    int unsigned cyc = 0;

    prog_loader_if #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) bus ();

    prog_loader #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // RAM model and strobe monitor
    logic [WIDTH-1:0]  ram [16];
    logic              prev_wr_n = 1'b1;
    logic [AWIDTH-1:0] prev_addr = '0;
    logic [WIDTH-1:0]  prev_data = '0;
    int strobes = 0;
    int aborts  = 0;
    int bad     = 0;
    int addr_log[$];

    always @(negedge clock) begin
        if (prev_wr_n === 1'b0 && bus.mem_wr_n === 1'b1) begin
            if (bus.mem_drive !== 1'b1) aborts++;
            else if (bus.mem_addr !== prev_addr || bus.mem_data !== prev_data) bad++;
            else begin
                ram[prev_addr] = prev_data;
                strobes++;
                addr_log.push_back(int'(prev_addr));
            end
        end
        if (bus.mem_wr_n === 1'b0 && bus.mem_drive !== 1'b1) bad++;
        prev_wr_n = bus.mem_wr_n;
        prev_addr = bus.mem_addr;
        prev_data = bus.mem_data;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time expired, got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Present one word and complete the handshake; t = cycle of acceptance
    task automatic send_word(input logic [WIDTH-1:0] d, output int unsigned t);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        if (n >= 10) begin
            vectors++; miscompares++;
            $display("FAIL send_word_timeout: in_ready=%b want 1", bus.in_ready);
        end
        t = cyc;
        step();
        bus.in_valid = 1'b0;
    endtask

    // Full load of base + stepv*i; optional 5-cycle stall before word gap_at,
    // optionally with a start pulse in the middle of the stall
    task automatic run_load(input logic [WIDTH-1:0] base, input logic [WIDTH-1:0] stepv,
                            input int gap_at, input bit start_in_gap, input string tag);
        logic [WIDTH-1:0] exp_d [16];
        logic [WIDTH-1:0] sum = '0;
        int log0 = addr_log.size();
        int s0 = strobes;
        int b0 = bad;
        int unsigned t0 = 0;
        int unsigned t;
        int n = 0;
        int unsigned want_cyc;
        for (int i = 0; i < 16; i++) begin
            exp_d[i] = base + stepv * WIDTH'(i);
            if (i == gap_at) begin
                while (bus.in_ready !== 1'b1 && n < 10) begin step(); n++; end
                for (int k = 0; k < 5; k++) begin
                    vectors++;
                    if (bus.in_ready !== 1'b1) begin
                        miscompares++;
                        $display("FAIL %s gap_in_ready: got %b want 1", tag, bus.in_ready);
                    end
                    if (start_in_gap && k == 2) bus.start = 1'b1;
                    step();
                    bus.start = 1'b0;
                end
                vectors++;
                if (strobes != s0 + i) begin
                    miscompares++;
                    $display("FAIL %s gap_strobes: got %0d want %0d", tag, strobes - s0, i);
                end
            end
            sum += exp_d[i];
            send_word(exp_d[i], t);
            if (i == 0) t0 = t;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_word(sum, t);
        want_cyc = 49;
`else
        want_cyc = 48;
`endif
        if (gap_at >= 0) want_cyc += 5;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin step(); n++; end
        vectors++;
        if (cyc - t0 != want_cyc) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", tag, cyc - t0, want_cyc);
        end
        vectors++;
        if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_outputs: got done=%b cpu_reset=%b in_ready=%b want 1 0 0",
                     tag, bus.done, bus.cpu_reset, bus.in_ready);
        end
        vectors++;
        if (strobes - s0 != 16 || bad != b0) begin
            miscompares++;
            $display("FAIL %s strobe_count: got %0d (bad %0d) want 16 (bad 0)", tag, strobes - s0, bad - b0);
        end
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (log0 + i >= addr_log.size() || addr_log[log0 + i] != i) begin
                miscompares++;
                $display("FAIL %s strobe_addr[%0d]: got %0d want %0d", tag, i,
                         (log0 + i < addr_log.size()) ? addr_log[log0 + i] : -1, i);
            end
            vectors++;
            if (ram[i] !== exp_d[i]) begin
                miscompares++;
                $display("FAIL %s ram[%0d]: got %h want %h", tag, i, ram[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        step(); step();
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.mem_drive !== 1'b0 || bus.mem_wr_n !== 1'b1 ||
            bus.mem_addr !== 4'd0 || bus.mem_data !== 6'd0 || bus.cpu_reset !== 1'b1 ||
            bus.done !== 1'b0 || bus.error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: got rdy=%b drv=%b wr_n=%b addr=%h data=%h cpu_rst=%b done=%b err=%b want 0 0 1 0 0 1 0 0",
                     bus.in_ready, bus.mem_drive, bus.mem_wr_n, bus.mem_addr, bus.mem_data,
                     bus.cpu_reset, bus.done, bus.error);
        end
        reset = 1'b0;
        bus.in_valid = 1'b1;
        step(); step();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.cpu_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_hold: got in_ready=%b cpu_reset=%b want 0 1", bus.in_ready, bus.cpu_reset);
        end
    endtask

    task automatic test_basic_load();
        pulse_start();
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.cpu_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL start_recv: got in_ready=%b cpu_reset=%b want 1 1", bus.in_ready, bus.cpu_reset);
        end
        run_load(6'h00, 6'h01, -1, 1'b0, "basic");
        step(); step(); step();
        vectors++;
        if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0 || bus.mem_drive !== 1'b0) begin
            miscompares++;
            $display("FAIL done_hold: got done=%b cpu_reset=%b mem_drive=%b want 1 0 0",
                     bus.done, bus.cpu_reset, bus.mem_drive);
        end
    endtask

    task automatic test_stall_load();
        pulse_start();
        vectors++;
        if (bus.cpu_reset !== 1'b1 || bus.done !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL restart: got cpu_reset=%b done=%b in_ready=%b want 1 0 1",
                     bus.cpu_reset, bus.done, bus.in_ready);
        end
        run_load(6'h15, 6'h05, 7, 1'b0, "stall");
    endtask

    task automatic test_reset_mid_write();
        int unsigned t;
        int a0;
        int n = 0;
        pulse_start();
        send_word(6'h2A, t);
        send_word(6'h2B, t);
        send_word(6'h2C, t);
        bus.in_valid = 1'b1;
        bus.in_data  = 6'h33;
        while (bus.in_ready !== 1'b1 && n < 10) begin step(); n++; end
        step();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.mem_wr_n !== 1'b0 || bus.mem_addr !== 4'd3) begin
            miscompares++;
            $display("FAIL midwrite_setup: got wr_n=%b addr=%0d want 0 3", bus.mem_wr_n, bus.mem_addr);
        end
        a0 = aborts;
        reset = 1'b1;
        bus.start = 1'b1;
        step();
        reset = 1'b0;
        bus.start = 1'b0;
        vectors++;
        if (bus.mem_wr_n !== 1'b1 || bus.mem_drive !== 1'b0 || bus.cpu_reset !== 1'b1 ||
            bus.in_ready !== 1'b0 || bus.mem_addr !== 4'd0 || aborts != a0 + 1) begin
            miscompares++;
            $display("FAIL midwrite_reset: got wr_n=%b drv=%b cpu_rst=%b rdy=%b addr=%0d aborts=%0d want 1 0 1 0 0 1",
                     bus.mem_wr_n, bus.mem_drive, bus.cpu_reset, bus.in_ready, bus.mem_addr, aborts - a0);
        end
        pulse_start();
        run_load(6'h30, 6'h03, -1, 1'b0, "reload");
    endtask

    task automatic test_start_ignored();
        pulse_start();
        run_load(6'h3F, 6'h07, 9, 1'b1, "start_ign");
    endtask

    task automatic test_reset_priority();
        reset = 1'b1;
        bus.start = 1'b1;
        bus.in_valid = 1'b1;
        step();
        reset = 1'b0;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.done !== 1'b0 || bus.cpu_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_priority: got in_ready=%b done=%b cpu_reset=%b want 0 0 1",
                     bus.in_ready, bus.done, bus.cpu_reset);
        end
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int unsigned t;
        int n;
        for (int pass = 0; pass < 2; pass++) begin
            pulse_start();
            for (int i = 0; i < 16; i++) send_word(6'h3F, t);
            send_word((pass == 0) ? 6'h30 : 6'h31, t);
            n = 0;
            while (bus.done !== 1'b1 && bus.error !== 1'b1 && n < 10) begin step(); n++; end
            vectors++;
            if (pass == 0 && (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.cpu_reset !== 1'b0)) begin
                miscompares++;
                $display("FAIL checksum_match: got done=%b error=%b cpu_reset=%b want 1 0 0",
                         bus.done, bus.error, bus.cpu_reset);
            end
            if (pass == 1 && (bus.done !== 1'b0 || bus.error !== 1'b1 || bus.cpu_reset !== 1'b1)) begin
                miscompares++;
                $display("FAIL checksum_mismatch: got done=%b error=%b cpu_reset=%b want 0 1 1",
                         bus.done, bus.error, bus.cpu_reset);
            end
        end
        pulse_start();
        vectors++;
        if (bus.error !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL error_restart: got error=%b in_ready=%b want 0 1", bus.error, bus.in_ready);
        end
    endtask
`else
    task automatic test_checksum();
        vectors++;
        if (bus.error !== 1'b0) begin
            miscompares++;
            $display("FAIL error_tied: got %b want 0", bus.error);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_stall_load();
        test_reset_mid_write();
        test_start_ignored();
        test_checksum();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
